// File: rtl/lane_output_monitor.sv
// ---------------------------------------------------------------------------
// lane_output_monitor
//
// Receiving end of the 8-bit laneOutput bus. Decodes four 2-bit lane fields,
// checks each lane's transitions and minimum dwell times, checks that the two
// axes never show GREEN/YELLOW together, and registers the bus to the lamp
// drivers. Any violation latches a fault and forces all lamps RED until a
// supervised recovery (fault_clr, then RECOVER_CYCLES consecutive all-RED
// input samples).
//
// Ports
//   clk         in   1  rising-edge clock
//   rst_n       in   1  asynchronous active-low reset
//   lane_in     in   8  lane i = bits[2i+1:2i]; 00 RED, 01 YELLOW, 10 GREEN, 11 FLASH
//   fault_clr   in   1  single-cycle request to leave FAULT
//   lamp_out    out  8  registered lamp drive, same encoding as lane_in
//   fault       out  1  high in FAULT and RECOVER
//   fault_code  out  3  0 none, 1 axis conflict, 2 illegal transition,
//                       3 green dwell short, 4 yellow dwell short
//   fault_lane  out  2  lane index of the first violation (0 for axis conflict)
// ---------------------------------------------------------------------------
module lane_output_monitor #(
    parameter int MIN_GREEN      = 16,
    parameter int MIN_YELLOW     = 4,
    parameter int RECOVER_CYCLES = 8,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] lane_in,
    input  logic       fault_clr,
    output logic [7:0] lamp_out,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_lane
);

    localparam logic [1:0] L_RED = 2'b00;
    localparam logic [1:0] L_YEL = 2'b01;
    localparam logic [1:0] L_GRN = 2'b10;
    localparam logic [1:0] L_FLS = 2'b11;

    localparam logic [2:0] C_NONE     = 3'd0;
    localparam logic [2:0] C_CONFLICT = 3'd1;
    localparam logic [2:0] C_ILLEGAL  = 3'd2;
    localparam logic [2:0] C_GREEN    = 3'd3;
    localparam logic [2:0] C_YELLOW   = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] MIN_G    = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MIN_Y    = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(RECOVER_CYCLES - 1);

    typedef enum logic [1:0] {ST_MONITOR, ST_FAULT, ST_RECOVER} state_t;

    state_t           state;
    logic [1:0]       prev  [4];
    logic [CNT_W-1:0] dwell [4];
    logic [CNT_W-1:0] rec_cnt;

    logic [1:0] cur [4];
    logic [3:0] illegal, green_short, yellow_short;
    logic       conflict;
    logic       viol;
    logic [2:0] viol_code;
    logic [1:0] viol_lane;

    // FLASH is deliberately not "active": only GREEN/YELLOW can conflict.
    function automatic logic is_go(input logic [1:0] v);
        return (v == L_GRN) || (v == L_YEL);
    endfunction

    function automatic logic is_legal(input logic [1:0] p, input logic [1:0] c);
        return (p == c) ||
               (p == L_RED && c == L_GRN) || (p == L_GRN && c == L_YEL) ||
               (p == L_YEL && c == L_RED) || (p == L_RED && c == L_FLS) ||
               (p == L_FLS && c == L_RED);
    endfunction

    // Descending scan so the lowest set index is the one that sticks.
    function automatic logic [1:0] first_set(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

    // NOTE: every always_comb output gets a default up front so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        illegal      = '0;
        green_short  = '0;
        yellow_short = '0;
        for (int i = 0; i < 4; i++) begin
            cur[i]          = lane_in[2*i +: 2];
            illegal[i]      = !is_legal(prev[i], cur[i]);
            green_short[i]  = (prev[i] == L_GRN) && (cur[i] == L_YEL) && (dwell[i] < MIN_G);
            yellow_short[i] = (prev[i] == L_YEL) && (cur[i] == L_RED) && (dwell[i] < MIN_Y);
        end
        conflict = (is_go(cur[0]) || is_go(cur[2])) && (is_go(cur[1]) || is_go(cur[3]));

        viol_code = C_NONE;
        viol_lane = 2'd0;
        if (conflict) begin
            viol_code = C_CONFLICT;
        end else if (|illegal) begin
            viol_code = C_ILLEGAL;
            viol_lane = first_set(illegal);
        end else if (|green_short) begin
            viol_code = C_GREEN;
            viol_lane = first_set(green_short);
        end else if (|yellow_short) begin
            viol_code = C_YELLOW;
            viol_lane = first_set(yellow_short);
        end
        viol = (viol_code != C_NONE);
    end

    // Per-lane history runs in every state so dwell is correct when
    // monitoring resumes after a recovery.
    // NOTE: the history arrays are only four entries each and feed the checks
    // directly, so they are reset like any other register rather than left
    // uninitialised like a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                prev[i]  <= L_RED;
                dwell[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (cur[i] != prev[i]) begin
                    prev[i]  <= cur[i];
                    dwell[i] <= CNT_W'(1);
                end else if (dwell[i] != CNT_MAX) begin
                    dwell[i] <= dwell[i] + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_MONITOR;
            lamp_out   <= 8'h00;
            fault      <= 1'b0;
            fault_code <= C_NONE;
            fault_lane <= 2'd0;
            rec_cnt    <= '0;
        end else begin
            case (state)
                ST_MONITOR: begin
                    if (viol) begin
                        state      <= ST_FAULT;
                        lamp_out   <= 8'h00;
                        fault      <= 1'b1;
                        fault_code <= viol_code;
                        fault_lane <= viol_lane;
                    end else begin
                        lamp_out <= lane_in;
                    end
                end
                ST_FAULT: begin
                    lamp_out <= 8'h00;
                    if (fault_clr) begin
                        state   <= ST_RECOVER;
                        rec_cnt <= '0;
                    end
                end
                ST_RECOVER: begin
                    lamp_out <= 8'h00;
                    if (lane_in == 8'h00) begin
                        if (rec_cnt == REC_LAST) begin
                            state      <= ST_MONITOR;
                            fault      <= 1'b0;
                            fault_code <= C_NONE;
                            fault_lane <= 2'd0;
                            rec_cnt    <= '0;
                        end else begin
                            rec_cnt <= rec_cnt + CNT_W'(1);
                        end
                    end else begin
                        rec_cnt <= '0;
                    end
                end
                default: state <= ST_MONITOR;
            endcase
        end
    end

endmodule

// File: tb/tb_lane_output_monitor.sv
// ---------------------------------------------------------------------------
// tb_lane_output_monitor
//
// Directed stimulus for lane_output_monitor. The driver applies one lane_in
// sample per cycle on the falling edge and queues the hand-computed outputs
// expected after the next rising edge; an independent monitor pops and
// compares one entry per cycle shortly after each rising edge.
// ---------------------------------------------------------------------------
module tb_lane_output_monitor;

    typedef struct packed {
        logic [7:0] lamp;
        logic       flt;
        logic [2:0] code;
        logic [1:0] lane;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] lane_in = 8'h00;
    logic       fault_clr = 1'b0;
    logic [7:0] lamp_out;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_lane;

    exp_t  sb_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    lane_output_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lane_in    (lane_in),
        .fault_clr  (fault_clr),
        .lamp_out   (lamp_out),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_lane (fault_lane)
    );

    always #5 clk = ~clk;

    function automatic exp_t ok(input logic [7:0] l);
        return {l, 1'b0, 3'd0, 2'd0};
    endfunction

    function automatic exp_t flt(input logic [2:0] c, input logic [1:0] ln);
        return {8'h00, 1'b1, c, ln};
    endfunction

    task automatic compare(input exp_t e, input string tag);
        exp_t got;
        got = {lamp_out, fault, fault_code, fault_lane};
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL %s: got lamp=%h fault=%b code=%0d lane=%0d, want lamp=%h fault=%b code=%0d lane=%0d",
                     tag, got.lamp, got.flt, got.code, got.lane, e.lamp, e.flt, e.code, e.lane);
        end
    endtask

    // Monitor: one output per cycle whenever an expectation is pending.
    exp_t  mon_e;
    string mon_t;
    always @(posedge clk) begin
        #1;
        if (rst_n && sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            mon_t = tag_q.pop_front();
            compare(mon_e, mon_t);
        end
    end

    task automatic step(input logic [7:0] l, input logic clr, input exp_t e, input string tag);
        @(negedge clk);
        lane_in   = l;
        fault_clr = clr;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic run(input logic [7:0] l, input int n, input exp_t e, input string tag);
        for (int i = 0; i < n; i++) step(l, 1'b0, e, tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        lane_in   = 8'h00;
        fault_clr = 1'b0;
        #1;
        compare(ok(8'h00), "reset_values");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Legal cycle on lane0 then lane2, dwell exactly at the minimums.
        do_reset();
        run(8'h00, 2, ok(8'h00), "legal_red");
        run(8'h02, 16, ok(8'h02), "legal_l0_green");
        run(8'h01, 4, ok(8'h01), "legal_l0_yellow");
        run(8'h00, 2, ok(8'h00), "legal_l0_red");
        step(8'h00, 1'b1, ok(8'h00), "clr_in_monitor");
        run(8'h20, 16, ok(8'h20), "legal_l2_green");
        run(8'h10, 4, ok(8'h10), "legal_l2_yellow");
        run(8'h00, 2, ok(8'h00), "legal_l2_red");

        // Axis conflict, fault hold, then supervised recovery with a restart.
        do_reset();
        step(8'h02, 1'b0, ok(8'h02), "pre_conflict");
        step(8'h0A, 1'b0, flt(3'd1, 2'd0), "conflict");
        step(8'h0A, 1'b0, flt(3'd1, 2'd0), "conflict_hold");
        step(8'h00, 1'b0, flt(3'd1, 2'd0), "fault_ignores_viol");
        step(8'h00, 1'b1, flt(3'd1, 2'd0), "fault_clr");
        run(8'h00, 7, flt(3'd1, 2'd0), "recover_zeros7");
        step(8'h55, 1'b0, flt(3'd1, 2'd0), "recover_restart");
        run(8'h00, 7, flt(3'd1, 2'd0), "recover_zeros_1to7");
        step(8'h00, 1'b0, ok(8'h00), "recover_exit");
        step(8'h02, 1'b0, ok(8'h02), "resume_follow");

        // Short green on lane3.
        do_reset();
        run(8'h80, 5, ok(8'h80), "l3_green5");
        step(8'h40, 1'b0, flt(3'd3, 2'd3), "short_green_l3");
        step(8'h40, 1'b0, flt(3'd3, 2'd3), "short_green_hold");

        // Green one cycle short of the minimum on lane0.
        do_reset();
        run(8'h02, 15, ok(8'h02), "l0_green15");
        step(8'h01, 1'b0, flt(3'd3, 2'd0), "short_green_boundary");

        // Illegal GREEN->RED on lane1.
        do_reset();
        run(8'h08, 3, ok(8'h08), "l1_green");
        step(8'h00, 1'b0, flt(3'd2, 2'd1), "illegal_l1");

        // Short yellow on lane1.
        do_reset();
        run(8'h08, 16, ok(8'h08), "l1_green16");
        run(8'h04, 2, ok(8'h04), "l1_yellow2");
        step(8'h00, 1'b0, flt(3'd4, 2'd1), "short_yellow_l1");

        // Simultaneous: lane2 YELLOW->GREEN (illegal) with lane0 short yellow.
        do_reset();
        run(8'h22, 16, ok(8'h22), "axisA_green16");
        run(8'h11, 2, ok(8'h11), "axisA_yellow2");
        step(8'h20, 1'b0, flt(3'd2, 2'd2), "priority_illegal");

        // Night mode and mixed FLASH.
        do_reset();
        run(8'hFF, 100, ok(8'hFF), "night_flash");
        run(8'h00, 3, ok(8'h00), "night_red");
        step(8'h08, 1'b0, ok(8'h08), "mix_l1_green");
        step(8'h0B, 1'b0, ok(8'h0B), "mix_flash_green");
        step(8'h08, 1'b0, ok(8'h08), "mix_flash_off");

        // Asynchronous reset in the middle of RECOVER.
        do_reset();
        step(8'h0A, 1'b0, flt(3'd1, 2'd0), "conflict2");
        step(8'h00, 1'b1, flt(3'd1, 2'd0), "fault_clr2");
        run(8'h00, 3, flt(3'd1, 2'd0), "recover_partial");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        compare(ok(8'h00), "async_reset_mid_recover");
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
